rom_read_arbiter: RTL
=====================

// Module: rom_read_arbiter
// PURPOSE
//  Shares the single rom instance (address/sel/data) among N_REQ requesters.
//  Each requester presents an address plus a req level; the arbiter grants one
//  requester at a time (round-robin), drives the rom, registers the returned
//  byte, and pulses a per-requester valid. Sits between client FSMs and rom.
// PARAMETERS
//  N_REQ  4  number of requesters (2..8)
//  AW     2  rom address width
//  DW     8  rom data width
// PORTS
//  clk          in   1         system clock, all logic on rising edge
//  rst          in   1         synchronous, active-high reset
//  req          in   N_REQ     per-requester read request, level, held until done
//  req_addr     in   N_REQ*AW  packed addresses; requester i at [i*AW +: AW]
//  gnt          out  N_REQ     one-hot grant, high in READ and DONE
//  done         out  N_REQ     one-hot, 1-cycle pulse: rd_data valid for that requester
//  rd_data      out  DW        registered rom byte for the last completed read
//  rom_address  out  AW        to rom.address
//  rom_sel      out  1         to rom.sel
//  rom_data     in   DW        from rom.data (combinational rom output)
// BEHAVIOUR
//  - Reset: state=IDLE, rr_ptr=0, gnt=0, done=0, rd_data=0, rom_sel=0, rom_address=0.
//  - FSM IDLE -> READ -> DONE -> IDLE, all transitions registered.
//  - IDLE: if |req, winner = first asserted req scanning from rr_ptr upward
//    with wrap at N_REQ-1 -> 0; latch winner id and req_addr[id] -> READ.
//    No req: stay IDLE; rom_sel=0.
//  - READ: rom_sel=1, rom_address=latched addr; at end of cycle rd_data<=rom_data
//    -> DONE.
//  - DONE: done[id]=1 for exactly this cycle; rom_sel=0; rr_ptr<=(id+1) mod
//    N_REQ -> IDLE.
//  - Latency: req seen in IDLE -> done pulse 2 cycles later. Max throughput one
//    read per 3 cycles.
//  - rd_data holds its value until the next READ capture.
//  - Address latched in IDLE; changes to req_addr during READ/DONE are ignored.
//  - req dropped after grant: read still completes and done still pulses (no cancel).
//  - Requester must deassert req in the cycle after its done or it re-enters
//    arbitration at lowest round-robin priority.
//  - Simultaneous req: only the winner is served; others wait, no starvation
//    (each waits at most N_REQ-1 services).
//  - rst mid-READ/DONE: back to IDLE next edge, no done pulse, rd_data=0.
//  - Address width: no arithmetic on addresses; AW passed straight through.
// CONFIGURATION
//  ROM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins; rr_ptr
//    unused and held at 0.
//  Not defined: round-robin as above.
// TESTING
//  Bench rom model: rom_data = 8'hA0 + rom_address while rom_sel=1, else 8'h00.
//  1 single: req=4'b0001, addr0=2 -> rom_sel high 1 cycle with rom_address=2;
//    done=4'b0001, rd_data=8'hA2 two cycles after request.
//  2 contention: req=4'b1111, addrs 0/1/2/3 held -> done order 0,1,2,3, one per
//    3 cycles; rd_data A0,A1,A2,A3.
//  3 fairness: after serving req1, assert req0 and req2 together -> req2 served
//    first (rr_ptr=2); with ROM_ARB_FIXED_PRIO_EN -> req0 first.
//  4 addr change: req3 addr=1, change addr to 3 during READ -> rd_data=8'hA1.
//  5 reset: assert rst during READ -> next cycle gnt=0, rom_sel=0, rd_data=0,
//    no done pulse; after release, req0 addr 3 -> rd_data=8'hA3.
//  6 idle: req=0 for 20 cycles -> rom_sel, gnt, done stay 0.

Source files
------------

// File: rtl/rom_read_arbiter.sv
// Round-robin read arbiter sharing one rom among N_REQ requesters; done pulses 2 cycles after req, one read per 3 cycles.
// Define ROM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, rr pointer held at 0); requesters wait on req level.
module rom_read_arbiter #(
   parameter int N_REQ = 4,
   parameter int AW    = 2,
   parameter int DW    = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [N_REQ-1:0]   i_req,
   input  logic [N_REQ*AW-1:0] i_req_addr,
   output logic [N_REQ-1:0]   o_gnt,
   output logic [N_REQ-1:0]   o_done,
   output logic [DW-1:0]      o_rd_data,
   output logic [AW-1:0]      o_rom_address,
   output logic               o_rom_sel,
   input  logic [DW-1:0]      i_rom_data
);

   localparam int IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int IW1 = IW + 1;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;

   state_t          r_state;
   logic [IW-1:0]   r_id;
   logic [IW-1:0]   r_rr_ptr;

   logic [IW1-1:0]  w_idx;
   logic            w_win_vld;
   logic [IW-1:0]   w_win_id;
   logic [AW-1:0]   w_win_addr;

   // Scan downward so the last hit, i.e. the one closest to the pointer, wins.
   always_comb begin
      w_win_vld = 1'b0;
      w_win_id  = '0;
      w_idx     = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_idx = IW1'(r_rr_ptr) + IW1'(k);
         if (w_idx >= IW1'(N_REQ))
            w_idx = w_idx - IW1'(N_REQ);
         if (i_req[w_idx[IW-1:0]]) begin
            w_win_vld = 1'b1;
            w_win_id  = w_idx[IW-1:0];
         end
      end
   end

   assign w_win_addr = i_req_addr[int'(w_win_id)*AW +: AW];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_id          <= '0;
         r_rr_ptr      <= '0;
         o_gnt         <= '0;
         o_done        <= '0;
         o_rd_data     <= '0;
         o_rom_address <= '0;
         o_rom_sel     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_win_vld) begin
                  r_id          <= w_win_id;
                  o_rom_address <= w_win_addr;
                  o_rom_sel     <= 1'b1;
                  o_gnt         <= N_REQ'(1) << w_win_id;
                  r_state       <= S_READ;
               end
            end
            S_READ: begin
               o_rd_data <= i_rom_data;
               o_rom_sel <= 1'b0;
               o_done    <= N_REQ'(1) << r_id;
               r_state   <= S_DONE;
            end
            S_DONE: begin
               o_done  <= '0;
               o_gnt   <= '0;
`ifndef ROM_ARB_FIXED_PRIO_EN
               r_rr_ptr <= (r_id == IW'(N_REQ - 1)) ? '0 : r_id + 1'b1;
`endif
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
